// File: rtl/conc_trace_recorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : conc_trace_recorder                                           |
// | Purpose  : Samples DUT-side pins every cycle after a trigger and packs   |
// |            them into trace bytes {obs, strobe, data[5:0]} stored in an   |
// |            internal RAM. The RAM is read back through a 1-cycle          |
// |            synchronous read port.                                        |
// | Ports    : clock, reset (sync, active-high)                              |
// |            arm / stop         session control pulses                     |
// |            obs_in, stb_in, x_in  sampled DUT pins (obs_in = trigger)     |
// |            rd_addr / rd_data  trace read port (read-before-write)       |
// |            count              bytes written this session                 |
// |            busy / done / full session status                             |
// |            delta_cnt          (optional) cycles since trigger at the     |
// |                               last write                                 |
// | Options  : `define CONC_TRACE_CHANGE_ONLY_EN to record only samples that |
// |            differ from the last written byte and to expose delta_cnt.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module conc_trace_recorder #(
    parameter int DEPTH      = 128,
    parameter int AW         = 7,
    parameter int START_ADDR = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          arm,
    input  logic          stop,
    input  logic          obs_in,
    input  logic          stb_in,
    input  logic [5:0]    x_in,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          full
`ifdef CONC_TRACE_CHANGE_ONLY_EN
    ,
    output logic [5:0]    delta_cnt
`endif
);

    localparam logic [AW-1:0] C_START_ADDR = AW'(START_ADDR);
    localparam logic [AW-1:0] C_LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [AW:0]   C_CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        state_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   count_q;
    logic          busy_q;
    logic          done_q;
    logic          full_q;
    logic [7:0]    rd_data_q;
    logic [7:0]    mem_q [DEPTH];

    logic [7:0]    w_sample;
    logic          w_trig;
    logic          w_cap;
    logic          w_wr_en;
    logic          w_last_slot;

`ifdef CONC_TRACE_CHANGE_ONLY_EN
    logic [7:0]    last_q;
    logic [5:0]    cyc_since_q;
    logic [5:0]    delta_q;
`endif

    assign w_sample    = {obs_in, stb_in, x_in};
    assign w_last_slot = (wr_ptr_q == C_LAST_ADDR);

    // Trigger cycle: wr_ptr already sits at the start address (set on arm/reset).
    assign w_trig = (state_q == S_ARMED) && !stop && obs_in;

`ifdef CONC_TRACE_CHANGE_ONLY_EN
    assign w_cap = (state_q == S_CAPTURE) && !stop && (w_sample != last_q);
`else
    assign w_cap = (state_q == S_CAPTURE) && !stop;
`endif

    assign w_wr_en = !reset && (w_trig || w_cap);

    // ------------------------------------------------------------------
    // Control FSM and session counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= C_START_ADDR;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            full_q   <= 1'b0;
`ifdef CONC_TRACE_CHANGE_ONLY_EN
            last_q      <= '0;
            cyc_since_q <= '0;
            delta_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state_q  <= S_ARMED;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        wr_ptr_q <= C_START_ADDR;
                        count_q  <= '0;
                        full_q   <= 1'b0;
`ifdef CONC_TRACE_CHANGE_ONLY_EN
                        cyc_since_q <= '0;
                        delta_q     <= '0;
`endif
                    end
                end
                S_ARMED: begin
                    if (stop) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (obs_in) begin
                        state_q <= S_CAPTURE;
`ifdef CONC_TRACE_CHANGE_ONLY_EN
                        // The trigger cycle is cycle 0; the next capture
                        // cycle is cycle 1.
                        cyc_since_q <= 6'd1;
                        delta_q     <= 6'd0;
`endif
                    end
                end
                S_CAPTURE: begin
                    if (stop) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
`ifdef CONC_TRACE_CHANGE_ONLY_EN
                        if (cyc_since_q != 6'd63) begin
                            cyc_since_q <= cyc_since_q + 6'd1;
                        end
                        if (w_cap) begin
                            delta_q <= cyc_since_q;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase

            // Write bookkeeping is shared by trigger and capture writes.
            // Writing the last slot overrides the state chosen above: the
            // session ends with full set and the pointer parked (no wrap).
            if (w_wr_en) begin
                count_q <= count_q + C_CNT_ONE;
`ifdef CONC_TRACE_CHANGE_ONLY_EN
                last_q  <= w_sample;
`endif
                if (w_last_slot) begin
                    full_q  <= 1'b1;
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Trace RAM: contents survive reset. The read register samples the
    // array before this edge's write lands, giving read-before-write.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= w_sample;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
    assign count   = count_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign full    = full_q;
`ifdef CONC_TRACE_CHANGE_ONLY_EN
    assign delta_cnt = delta_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conc_trace_recorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_conc_trace_recorder                                        |
// | Purpose  : Self-checking bench for conc_trace_recorder (DEPTH=8). A      |
// |            session-level model predicts every output each cycle;         |
// |            directed scenarios add literal expectations.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_conc_trace_recorder;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int START = 1;
`ifdef CONC_TRACE_CHANGE_ONLY_EN
    localparam bit CHG = 1'b1;
`else
    localparam bit CHG = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          arm;
    logic          stop;
    logic          obs_in;
    logic          stb_in;
    logic [5:0]    x_in;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          full;
`ifdef CONC_TRACE_CHANGE_ONLY_EN
    logic [5:0]    delta_cnt;
`endif

    conc_trace_recorder #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .START_ADDR (START)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .arm       (arm),
        .stop      (stop),
        .obs_in    (obs_in),
        .stb_in    (stb_in),
        .x_in      (x_in),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .full      (full)
`ifdef CONC_TRACE_CHANGE_ONLY_EN
        ,
        .delta_cnt (delta_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_tests++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Session model. phase: 0 = idle, 1 = waiting for trigger,
    // 2 = recording, 3 = finished. The next write address is always
    // START + number of bytes recorded so far.
    // ------------------------------------------------------------------
    int m_mem   [DEPTH];
    bit m_known [DEPTH];
    int m_phase = 0;
    int m_cnt   = 0;
    bit m_full  = 1'b0;
    int m_rd    = 0;
    bit m_rd_ok = 1'b0;
    int m_since = 0;
    int m_delta = 0;
    int m_last  = 0;

    function automatic void m_record(input int smp);
        int addr;
        addr          = START + m_cnt;
        m_mem[addr]   = smp;
        m_known[addr] = 1'b1;
        m_last        = smp;
        m_delta       = m_since;
        m_cnt++;
        if (addr == DEPTH - 1) begin
            m_full  = 1'b1;
            m_phase = 3;
        end
    endfunction

    always @(posedge clock) begin
        int smp;
        smp = int'({obs_in, stb_in, x_in});
        if (reset) begin
            m_phase = 0;
            m_cnt   = 0;
            m_full  = 1'b0;
            m_rd    = 0;
            m_rd_ok = 1'b1;
            m_delta = 0;
        end else begin
            m_rd    = m_mem[int'(rd_addr)];
            m_rd_ok = m_known[int'(rd_addr)];
            case (m_phase)
                0, 3: if (arm) begin
                    m_phase = 1;
                    m_cnt   = 0;
                    m_full  = 1'b0;
                    m_delta = 0;
                end
                1: if (stop) begin
                    m_phase = 3;
                end else if (obs_in) begin
                    m_phase = 2;
                    m_since = 0;
                    m_record(smp);
                    m_since = 1;
                end
                2: if (stop) begin
                    m_phase = 3;
                end else begin
                    if (!CHG || smp != m_last) m_record(smp);
                    m_since = (m_since >= 63) ? 63 : m_since + 1;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // One compare process, every cycle, away from the active edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            if (m_rd_ok) check("rd_data", 32'(rd_data), m_rd);
            check("count", 32'(count), m_cnt);
            check("busy",  32'(busy),  int'(m_phase == 1 || m_phase == 2));
            check("done",  32'(done),  int'(m_phase == 3));
            check("full",  32'(full),  int'(m_full));
`ifdef CONC_TRACE_CHANGE_ONLY_EN
            check("delta_cnt", 32'(delta_cnt), m_delta);
`endif
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input logic [7:0] b, input logic a, input logic s);
        obs_in = b[7];
        stb_in = b[6];
        x_in   = b[5:0];
        arm    = a;
        stop   = s;
        tick();
        arm  = 1'b0;
        stop = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [AW-1:0] a, input int exp);
        rd_addr = a;
        cyc(8'h00, 1'b0, 1'b0);
        check(name, 32'(rd_data), exp);
    endtask

    initial begin
        reset   = 1'b1;
        arm     = 1'b0;
        stop    = 1'b0;
        obs_in  = 1'b0;
        stb_in  = 1'b0;
        x_in    = '0;
        rd_addr = '0;
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_count",   32'(count),   0);
        check("rst_busy",    32'(busy),    0);
        check("rst_done",    32'(done),    0);
        check("rst_full",    32'(full),    0);
        reset = 1'b0;

        // Basic trigger/capture
        cyc(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0, 1'b0);
        check("armed_busy", 32'(busy), 1);
        cyc(8'h85, 1'b0, 1'b0);
        cyc(8'h41, 1'b0, 1'b0);
        cyc(8'h02, 1'b0, 1'b0);
        cyc(8'h3F, 1'b0, 1'b1);
        check("basic_count", 32'(count), 3);
        check("basic_done",  32'(done),  1);
        check("basic_busy",  32'(busy),  0);
        check("model_count", 32'(m_cnt), 3);
        read_chk("basic_rd1", 3'd1, 8'h85);
        read_chk("basic_rd2", 3'd2, 8'h41);
        read_chk("basic_rd3", 3'd3, 8'h02);
        check("model_mem3", 32'(m_mem[3]), 8'h02);

        // Stop while waiting for trigger
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);
        check("stoparm_done",  32'(done),  1);
        check("stoparm_count", 32'(count), 0);
        read_chk("stoparm_rd1", 3'd1, 8'h85);

        // Fill to the last slot
        cyc(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(8'(8'h80 + i), 1'b0, 1'b0);
        check("full_count", 32'(count), 7);
        check("full_full",  32'(full),  1);
        check("full_done",  32'(done),  1);
        check("model_full", 32'(m_full), 1);
        read_chk("full_rd7", 3'd7, 8'h86);
        read_chk("full_rd1", 3'd1, 8'h80);

        // Re-arm with arm and stop together from DONE
        cyc(8'h00, 1'b1, 1'b1);
        check("rearm_busy",  32'(busy),  1);
        check("rearm_done",  32'(done),  0);
        check("rearm_count", 32'(count), 0);
        check("rearm_full",  32'(full),  0);
        cyc(8'hC0, 1'b0, 1'b0);
        check("rearm_cnt1", 32'(count), 1);
        cyc(8'h11, 1'b0, 1'b1);
        read_chk("rearm_rd1", 3'd1, 8'hC0);

        // Reset mid-capture
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'hA1, 1'b0, 1'b0);
        cyc(8'h12, 1'b0, 1'b0);
        cyc(8'h23, 1'b0, 1'b0);
        cyc(8'h34, 1'b0, 1'b0);
        check("midrst_cnt4", 32'(count), 4);
        reset = 1'b1;
        cyc(8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        check("midrst_count", 32'(count), 0);
        check("midrst_done",  32'(done),  0);
        check("midrst_busy",  32'(busy),  0);
        read_chk("midrst_rd1", 3'd1, 8'hA1);

`ifdef CONC_TRACE_CHANGE_ONLY_EN
        // Change-only recording
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h81, 1'b0, 1'b0);
        cyc(8'h81, 1'b0, 1'b0);
        cyc(8'h81, 1'b0, 1'b0);
        cyc(8'h05, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);
        check("chg_count", 32'(count),     2);
        check("chg_delta", 32'(delta_cnt), 3);
        check("model_chg_delta", 32'(m_delta), 3);
        read_chk("chg_rd2", 3'd2, 8'h05);
`endif

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 299) == 0);
            rd_addr = AW'($urandom);
            cyc({1'($urandom_range(0, 3) == 0), 1'($urandom),
                 6'($urandom_range(0, 3))},
                1'($urandom_range(0, 11) == 0),
                1'($urandom_range(0, 19) == 0));
        end
        reset = 1'b0;
        tick();
        cmp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
